// File: rtl/row_reduce_controller.sv
// Row controller: gathers a pixel row, launches the conv engine, reduces its results to a
// max/min value plus index, and streams that out as a small byte frame.
module row_reduce_controller #(
   parameter int ROW_LEN  = 32,
   parameter int PIX_W    = 8,
   parameter int RES_W    = 18,
   parameter int NUM_RES  = 30,
   parameter int TX_BYTES = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       mode,
   input  logic                       abort,
   input  logic [PIX_W-1:0]           rx_data,
   input  logic                       rx_valid,
   output logic                       rx_ready,
   output logic                       eng_start,
   output logic [ROW_LEN*PIX_W-1:0]   eng_pixels,
   input  logic                       eng_done,
   input  logic [NUM_RES*RES_W-1:0]   eng_results,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic                       tx_last,
   output logic                       busy,
   output logic                       done
);

   // state   | meaning
   // IDLE    | waiting for start
   // RECEIVE | accepting ROW_LEN pixels
   // COMPUTE | engine running, waiting for eng_done
   // REDUCE  | one compare per cycle over stored results
   // SEND    | streaming value bytes then index byte

   localparam int CNT_W = $clog2(ROW_LEN);
   localparam int IDX_W = $clog2(NUM_RES);
   localparam int FR_W  = TX_BYTES * 8;
   localparam int BC_W  = $clog2(TX_BYTES + 1);

   typedef enum logic [2:0] {S_IDLE, S_RECEIVE, S_COMPUTE, S_REDUCE, S_SEND} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        pix_cnt;
   logic [IDX_W-1:0]        red_idx;
   logic [IDX_W-1:0]        best_idx;
   logic signed [RES_W-1:0] best;
   logic signed [RES_W-1:0] res_mem [NUM_RES];
   logic                    mode_q;
   logic [BC_W-1:0]         byte_cnt;

   logic signed [FR_W-1:0]  best_ext;
   logic [7:0]              idx_byte;
   logic [FR_W+7:0]         frame;
   logic [7:0]              frame_byte [TX_BYTES+1];
   logic                    better;

   always_comb begin
      best_ext = best;
      idx_byte = '0;
      idx_byte[IDX_W-1:0] = best_idx;
      frame = {idx_byte, best_ext};
      for (int k = 0; k <= TX_BYTES; k++)
         frame_byte[k] = frame[k*8 +: 8];
      // strict compare so ties keep the earliest index
      better = mode_q ? (res_mem[red_idx] < best) : (res_mem[red_idx] > best);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pix_cnt    <= '0;
         red_idx    <= '0;
         best_idx   <= '0;
         best       <= '0;
         mode_q     <= 1'b0;
         byte_cnt   <= '0;
         eng_pixels <= '0;
         rx_ready   <= 1'b0;
         eng_start  <= 1'b0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         tx_last    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i < NUM_RES; i++)
            res_mem[i] <= '0;
      end else begin
         eng_start <= 1'b0;
         done      <= 1'b0;
         if (abort) begin
            state    <= S_IDLE;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state    <= S_RECEIVE;
                     pix_cnt  <= '0;
                     mode_q   <= mode;
                     rx_ready <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
               S_RECEIVE: begin
                  if (rx_valid && rx_ready) begin
                     for (int i = 0; i < ROW_LEN; i++)
                        if (pix_cnt == CNT_W'(i))
                           eng_pixels[i*PIX_W +: PIX_W] <= rx_data;
                     if (pix_cnt == CNT_W'(ROW_LEN - 1)) begin
                        state     <= S_COMPUTE;
                        rx_ready  <= 1'b0;
                        eng_start <= 1'b1;
                     end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                     end
                  end
               end
               S_COMPUTE: begin
                  if (eng_done) begin
                     for (int i = 0; i < NUM_RES; i++)
                        res_mem[i] <= eng_results[i*RES_W +: RES_W];
                     best     <= eng_results[RES_W-1:0];
                     best_idx <= '0;
                     red_idx  <= IDX_W'(1);
                     state    <= S_REDUCE;
                  end
               end
               S_REDUCE: begin
                  if (better) begin
                     best     <= res_mem[red_idx];
                     best_idx <= red_idx;
                  end
                  if (red_idx == IDX_W'(NUM_RES - 1)) begin
                     state    <= S_SEND;
                     byte_cnt <= '0;
                  end else begin
                     red_idx <= red_idx + 1'b1;
                  end
               end
               S_SEND: begin
                  if (!tx_valid) begin
                     tx_valid <= 1'b1;
                     tx_data  <= frame_byte[0];
                     tx_last  <= 1'b0;
                     byte_cnt <= '0;
                  end else if (tx_ready) begin
                     if (tx_last) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        tx_data  <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                     end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                        tx_data  <= frame_byte[byte_cnt + 1'b1];
                        tx_last  <= ((byte_cnt + 1'b1) == BC_W'(TX_BYTES));
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
